vga_pattern_gen: RTL and testbench

- Parametrised VGA timing and test-pattern generator.
- Produces hsync, vsync, data-enable and pixel coordinates for any mode set by the timing parameters.
- Drives one of four selectable test patterns on the RGB outputs.
- Sits between the board pixel-clock source and the DAC/pin RGB/sync outputs. Downstream video blocks consume its x/y/de/frame_start outputs.

---
 rtl/vga_pkg.sv | 21 ++
 rtl/vga_timing_core.sv | 82 ++++++++
 rtl/vga_pattern_gen.sv | 98 +++++++++
 tb/tb_vga_pattern_gen.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// vga_pkg: pattern mode encodings, default 640x480@60 timing and the bar colour helper
package vga_pkg;
  typedef enum logic [1:0] {
    MODE_BARS     = 2'd0,
    MODE_CHECKER  = 2'd1,
    MODE_GRADIENT = 2'd2,
    MODE_SOLID    = 2'd3
  } mode_e;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  // {R,G,B} on/off for bar index mod 8: white, yellow, cyan, green, magenta, red, blue, black
  function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
    return {~idx[1], ~idx[2], ~idx[0]};
  endfunction
endpackage

// File: rtl/vga_timing_core.sv
// vga_timing_core: pixel/line counters plus registered x/y, de, syncs and frame_start
module vga_timing_core
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  output logic [HW-1:0] hcnt,
  output logic [VW-1:0] vcnt,
  output logic          de_raw,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          de,
  output logic          hsync,
  output logic          vsync,
  output logic          frame_start
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic HS_ON = 1'(HS_POL);
  localparam logic VS_ON = 1'(VS_POL);
  logic [HW-1:0] hcnt_q, hcnt_d, x_q, x_d;
  logic [VW-1:0] vcnt_q, vcnt_d, y_q, y_d;
  logic de_q, de_d, hsync_q, hsync_d, vsync_q, vsync_d, fs_q, fs_d;
  logic h_wrap, hs_act, vs_act;
  always_comb begin
    h_wrap  = hcnt_q == HW'(H_TOTAL - 1);
    hcnt_d  = pix_en ? (h_wrap ? '0 : hcnt_q + 1'b1) : hcnt_q;
    vcnt_d  = (pix_en && h_wrap) ? (vcnt_q == VW'(V_TOTAL - 1) ? '0 : vcnt_q + 1'b1) : vcnt_q;
    de_raw  = hcnt_q < HW'(H_ACTIVE) && vcnt_q < VW'(V_ACTIVE);
    hs_act  = hcnt_q >= HW'(H_ACTIVE + H_FP) && hcnt_q < HW'(H_ACTIVE + H_FP + H_SYNC);
    vs_act  = vcnt_q >= VW'(V_ACTIVE + V_FP) && vcnt_q < VW'(V_ACTIVE + V_FP + V_SYNC);
    x_d     = pix_en ? hcnt_q : x_q;
    y_d     = pix_en ? vcnt_q : y_q;
    de_d    = pix_en ? de_raw : de_q;
    hsync_d = pix_en ? (hs_act ? HS_ON : ~HS_ON) : hsync_q;
    vsync_d = pix_en ? (vs_act ? VS_ON : ~VS_ON) : vsync_q;
    fs_d    = pix_en ? (hcnt_q == '0 && vcnt_q == '0) : fs_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      de_q    <= 1'b0;
      hsync_q <= ~HS_ON;
      vsync_q <= ~VS_ON;
      fs_q    <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      de_q    <= de_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      fs_q    <= fs_d;
    end
  end
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign x           = x_q;
  assign y           = y_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frame_start = fs_q;
endmodule

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: VGA timing plus bars/checker/gradient/solid test patterns.
// Define VGA_BORDER_EN to overlay a 1-pixel white border around the visible area.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int H_FP       = DEF_H_FP,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BP       = DEF_H_BP,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int V_FP       = DEF_V_FP,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BP       = DEF_V_BP,
  parameter int HS_POL     = 0,
  parameter int VS_POL     = 0,
  parameter int COLOR_W    = 4,
  parameter int NUM_BARS   = 8,
  parameter int CHK_LOG2   = 5,
  parameter int GRAD_SHIFT = 5,
  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic [1:0]           mode,
  input  logic [3*COLOR_W-1:0] solid_rgb,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 de,
  output logic [HW-1:0]        x,
  output logic [VW-1:0]        y,
  output logic                 frame_start
);
  localparam int CW      = COLOR_W;
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int BW      = H_ACTIVE / NUM_BARS;
  logic [HW-1:0] hcnt, inbar_q, inbar_d;
  logic [VW-1:0] vcnt;
  logic [3:0] bar_q, bar_d;
  logic [2:0] bar;
  mode_e mode_q, mode_d, mode_eff;
  logic [3*CW-1:0] solid_q, solid_d, solid_eff, pat, pix, rgb_q, rgb_d;
  logic de_raw, first, h_wrap, bar_end, chk;
  vga_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HS_POL(HS_POL), .VS_POL(VS_POL)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcnt(hcnt), .vcnt(vcnt), .de_raw(de_raw),
    .x(x), .y(y), .de(de), .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
  );
  // The (0,0) pixel already uses the newly latched mode so the change lines up with frame_start
  always_comb begin
    first     = hcnt == '0 && vcnt == '0;
    h_wrap    = hcnt == HW'(H_TOTAL - 1);
    bar_end   = inbar_q == HW'(BW - 1);
    inbar_d   = !pix_en ? inbar_q : (h_wrap || bar_end) ? '0 : inbar_q + 1'b1;
    bar_d     = !pix_en ? bar_q : h_wrap ? '0 : (bar_end && bar_q != 4'(NUM_BARS - 1)) ? bar_q + 1'b1 : bar_q;
    mode_eff  = first ? mode_e'(mode) : mode_q;
    solid_eff = first ? solid_rgb : solid_q;
    mode_d    = pix_en ? mode_eff : mode_q;
    solid_d   = pix_en ? solid_eff : solid_q;
    bar       = bar_rgb(bar_q[2:0]);
    chk       = hcnt[CHK_LOG2] ^ vcnt[CHK_LOG2];
    pat       = mode_eff == MODE_BARS ? {{CW{bar[2]}}, {CW{bar[1]}}, {CW{bar[0]}}}
              : mode_eff == MODE_CHECKER ? {3*CW{chk}}
              : mode_eff == MODE_GRADIENT ? {CW'(hcnt >> GRAD_SHIFT), CW'(vcnt >> GRAD_SHIFT), {CW{1'b0}}}
              : solid_eff;
`ifdef VGA_BORDER_EN
    pix       = (hcnt == '0 || hcnt == HW'(H_ACTIVE - 1) || vcnt == '0 || vcnt == VW'(V_ACTIVE - 1)) ? '1 : pat;
`else
    pix       = pat;
`endif
    rgb_d     = pix_en ? (de_raw ? pix : '0) : rgb_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inbar_q <= '0;
      bar_q   <= '0;
      mode_q  <= MODE_BARS;
      solid_q <= '0;
      rgb_q   <= '0;
    end else begin
      inbar_q <= inbar_d;
      bar_q   <= bar_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
      rgb_q   <= rgb_d;
    end
  end
  assign red   = rgb_q[3*CW-1 -: CW];
  assign green = rgb_q[2*CW-1 -: CW];
  assign blue  = rgb_q[CW-1:0];
endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb_vga_pattern_gen: scoreboard bench on a tiny 24x12 mode (16x8 visible, 3 bars of width 5).
module tb_vga_pattern_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [11:0] solid_rgb = 12'h000;
  logic [3:0] red, green, blue, y;
  logic [4:0] x;
  logic hsync, vsync, de, frame_start;
  int errors = 0;
  int checks = 0;
  int mh = 0, mv = 0, mm = 0;
  logic [11:0] ms = 12'h000;
  logic [24:0] sb_q[$];
  logic [24:0] last;
  localparam logic [24:0] RST_VAL = {13'b0000000000110, 12'h000};
  logic stat_en = 1'b0;
  int n_hs = 0, n_vs = 0, n_de = 0;
  logic [2:0] bar_tab [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

  vga_pattern_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(0), .VS_POL(0), .COLOR_W(4), .NUM_BARS(3), .CHK_LOG2(1), .GRAD_SHIFT(1)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .mode(mode), .solid_rgb(solid_rgb),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync), .de(de),
    .x(x), .y(y), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at x=%0d y=%0d", tag, act, exp, mh, mv);
    end
  endtask

  function automatic logic [24:0] model_out();
    logic de_r, hs, vs, fs;
    logic [11:0] c;
    logic [2:0] b;
    int idx;
    de_r = mh < 16 && mv < 8;
    hs = !(mh >= 18 && mh < 21);
    vs = !(mv >= 9 && mv < 11);
    fs = mh == 0 && mv == 0;
    case (mm)
      0: begin
        idx = mh / 5;
        if (idx > 2) idx = 2;
        b = bar_tab[idx];
        c = {{4{b[2]}}, {4{b[1]}}, {4{b[0]}}};
      end
      1: c = (((mh >> 1) ^ (mv >> 1)) & 1) != 0 ? 12'hfff : 12'h000;
      2: c = {4'(mh >> 1), 4'(mv >> 1), 4'h0};
      default: c = ms;
    endcase
`ifdef VGA_BORDER_EN
    if (mh == 0 || mh == 15 || mv == 0 || mv == 7) c = 12'hfff;
`endif
    if (!de_r) c = 12'h000;
    return {5'(mh), 4'(mv), de_r, hs, vs, fs, c};
  endfunction

  task automatic step(input logic pe);
    logic live;
    @(negedge clk);
    pix_en = pe;
    @(posedge clk);
    live = pe && !rst;
    if (live) begin
      if (mh == 0 && mv == 0) begin
        mm = int'(mode);
        ms = solid_rgb;
      end
      sb_q.push_back(model_out());
      if (mh == 23) begin
        mh = 0;
        mv = (mv == 11) ? 0 : mv + 1;
      end else mh++;
    end
    #1;
    if (live) last = sb_q.pop_front();
    check("timing", {19'd0, x, y, de, hsync, vsync, frame_start}, {19'd0, last[24:12]});
    check("rgb", {20'd0, red, green, blue}, {20'd0, last[11:0]});
    if (live && stat_en) begin
      n_hs += int'(!hsync);
      n_vs += int'(!vsync);
      n_de += int'(de);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  initial begin
    last = RST_VAL;
    step(1'b1);
    step(1'b0);
    rst = 1'b0;
    stat_en = 1'b1;
    run(96);
    mode = 2'd3;
    solid_rgb = 12'h5a3;
    run(192);
    stat_en = 1'b0;
    check("hs_low_per_frame", n_hs, 36);
    check("vs_low_per_frame", n_vs, 48);
    check("de_per_frame", n_de, 128);
    run(100);
    mode = 2'd1;
    run(188);
    run(100);
    mode = 2'd2;
    run(188);
    for (int i = 0; i < 288; i++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
      step(1'b0);
    end
    run(130);
    @(negedge clk);
    rst = 1'b1;
    #1;
    last = RST_VAL;
    sb_q.delete();
    mh = 0;
    mv = 0;
    mm = 0;
    check("async_rst_timing", {19'd0, x, y, de, hsync, vsync, frame_start}, {19'd0, last[24:12]});
    check("async_rst_rgb", {20'd0, red, green, blue}, {20'd0, last[11:0]});
    run(3);
    rst = 1'b0;
    step(1'b1);
    check("first_after_rst", {29'd0, x == 5'd0, y == 4'd0, frame_start}, 32'd7);
    run(50);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
